// File: rtl/lpc_packer.sv
// lpc_packer: downstream stage of the LPC decoder.
// Captures one transaction record on each rising edge of the decoder strobe.
// Records are buffered in a FIFO and serialized as 7-byte packets:
//   SYNC, {0,cyctype_dir}, addr[31:24], addr[23:16], addr[15:8], addr[7:0], data
// Ports:
//   clock, reset            - rising-edge clock, async active-low reset
//   in_cyctype_dir/addr/data - decoded transaction fields
//   in_clock_enable         - decoder strobe; each 0->1 transition is one transaction
//   out_byte/out_valid/out_ready - valid/ready byte stream to the UART
//   fifo_level              - records buffered (0..DEPTH)
//   overflow_count          - dropped records, saturating at 255
module lpc_packer #(
  parameter int          DEPTH     = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'h5A
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [3:0]               in_cyctype_dir,
  input  logic [31:0]              in_addr,
  input  logic [7:0]               in_data,
  input  logic                     in_clock_enable,
  output logic [7:0]               out_byte,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               overflow_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  // record layout: [43:40] cyctype_dir, [39:8] addr, [7:0] data
  typedef logic [43:0] rec_t;
  typedef enum logic {IDLE, SEND} state_e;

  state_e          state_q, state_d;
  logic            prev_en_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [7:0]      ovf_q, ovf_d;
  rec_t            hold_q, hold_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      out_byte_q, out_byte_d;
  logic            out_valid_q, out_valid_d;

  rec_t            mem [DEPTH];
  rec_t            rec_in, rec_rd;
  logic            capture, pop, wr, drop, xfer;

  function automatic logic [7:0] pick(input rec_t r, input logic [2:0] i);
    logic [7:0] b;
    case (i)
      3'd0:    b = SYNC_BYTE;
      3'd1:    b = {4'h0, r[43:40]};
      3'd2:    b = r[39:32];
      3'd3:    b = r[31:24];
      3'd4:    b = r[23:16];
      3'd5:    b = r[15:8];
      default: b = r[7:0];
    endcase
    return b;
  endfunction

  assign rec_in = {in_cyctype_dir, in_addr, in_data};
  assign rec_rd = mem[rd_ptr_q];

  always_comb begin
    capture = in_clock_enable & ~prev_en_q;
    pop     = (state_q == IDLE) && (level_q != '0);
    // a full FIFO still accepts when the serializer frees a slot this cycle
    wr      = capture && ((level_q != FULL) || pop);
    drop    = capture && !wr;
    xfer    = out_valid_q & out_ready;

    wr_ptr_d    = wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d     = level_q;
    if (wr && !pop)      level_d = level_q + LW'(1);
    else if (!wr && pop) level_d = level_q - LW'(1);
    ovf_d       = (drop && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;

    state_d     = state_q;
    hold_d      = hold_q;
    idx_d       = idx_q;
    out_byte_d  = out_byte_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: if (pop) begin
        hold_d      = rec_rd;
        idx_d       = 3'd0;
        out_byte_d  = SYNC_BYTE;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: if (xfer) begin
        if (idx_q == 3'd6) begin
          out_valid_d = 1'b0;
          out_byte_d  = 8'h00;
          state_d     = IDLE;
        end else begin
          idx_d      = idx_q + 3'd1;
          out_byte_d = pick(hold_q, idx_q + 3'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      prev_en_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ovf_q       <= '0;
      hold_q      <= '0;
      idx_q       <= '0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_en_q   <= in_clock_enable;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      hold_q      <= hold_d;
      idx_q       <= idx_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
    end
  end

  // storage needs no reset; only slots behind the write pointer are ever read
  always_ff @(posedge clock) begin
    if (wr) mem[wr_ptr_q] <= rec_in;
  end

  assign out_byte       = out_byte_q;
  assign out_valid      = out_valid_q;
  assign fifo_level     = level_q;
  assign overflow_count = ovf_q;
endmodule
